// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern decoder: display modes and run-control states.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_BLINK  = 2'd0,
    MODE_ONEHOT = 2'd1,
    MODE_BAR    = 2'd2,
    MODE_CHASE  = 2'd3
  } mode_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/led_tick_gen.sv
// Animation prescaler: counts 0..PRESCALE-1 while enabled and pulses tick on the last count.
module led_tick_gen #(
  parameter int PRESCALE = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;
  logic          last;

  assign last = (cnt == CW'(PRESCALE - 1));
  assign tick = en && last;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       cnt <= '0;
    else if (clr)  cnt <= '0;
    else if (en)   cnt <= last ? '0 : cnt + CW'(1);
  end

endmodule

// File: rtl/led_pattern_decoder.sv
// Selector-to-LED decoder with BLINK/ONEHOT/BAR/CHASE modes and start/idle run control.
// Optional LED_BOUNCE_EN: CHASE ping-pongs between the end LEDs instead of wrapping.
module led_pattern_decoder
  import led_pkg::*;
#(
  parameter int SEL_W    = 4,
  parameter int PRESCALE = 50_000_000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [SEL_W-1:0]      I,
  input  logic [1:0]            mode,
  input  logic                  start,
  input  logic                  idle,
  output logic [(1<<SEL_W)-1:0] LED,
  output logic                  running,
  output logic                  tick
);

  localparam int N_LED = 1 << SEL_W;

  state_e             state, state_next;
  logic               enter;
  logic [SEL_W-1:0]   pos;
  logic               phase;
  logic [N_LED-1:0]   led_d;
  logic [N_LED:0]     bar_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  // idle wins over start; start is a level, so holding it keeps RUN.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (start && !idle) state_next = ST_RUN;
      ST_RUN:  if (idle)           state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    running = (state == ST_RUN);
    enter   = (state == ST_IDLE) && start && !idle;
  end

  led_tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (running),
    .clr  (enter),
    .tick (tick)
  );

`ifdef LED_BOUNCE_EN
  logic dir_down;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos      <= '0;
      phase    <= 1'b0;
      dir_down <= 1'b0;
    end else if (enter) begin
      pos      <= I;
      phase    <= 1'b1;
      dir_down <= 1'b0;
    end else if (tick) begin
      phase <= ~phase;
      if (!dir_down) begin
        if (pos == '1) begin
          dir_down <= 1'b1;
          pos      <= pos - SEL_W'(1);
        end else begin
          pos <= pos + SEL_W'(1);
        end
      end else begin
        if (pos == '0) begin
          dir_down <= 1'b0;
          pos      <= SEL_W'(1);
        end else begin
          pos <= pos - SEL_W'(1);
        end
      end
    end
  end
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos   <= '0;
      phase <= 1'b0;
    end else if (enter) begin
      pos   <= I;
      phase <= 1'b1;
    end else if (tick) begin
      phase <= ~phase;
      pos   <= pos + SEL_W'(1);
    end
  end
`endif

  // Blanking on idle is applied here so the LEDs go dark on the same edge that leaves RUN.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    led_d    = '0;
    bar_full = (N_LED + 1)'(1) << I;
    bar_full = (bar_full << 1) - (N_LED + 1)'(1);
    if (running && !idle) begin
      case (mode_e'(mode))
        MODE_ONEHOT: led_d = N_LED'(1) << I;
        MODE_BAR:    led_d = bar_full[N_LED-1:0];
        MODE_BLINK:  led_d = phase ? (N_LED'(1) << I) : '0;
        MODE_CHASE:  led_d = N_LED'(1) << pos;
        default:     led_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) LED <= '0;
    else     LED <= led_d;
  end

endmodule

// File: tb/tb_led_pattern_decoder.sv
// Directed self-checking bench for led_pattern_decoder (SEL_W=4, PRESCALE=4).
module tb_led_pattern_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  sel;
  logic [1:0]  mode;
  logic        start;
  logic        idle;
  logic [15:0] led;
  logic        running;
  logic        tick;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [1:0]  mode;
    logic [3:0]  sel;
    logic [15:0] exp_led;
  } vec_t;

  vec_t vecs[8];

  led_pattern_decoder #(.SEL_W(4), .PRESCALE(4)) dut (
    .clk     (clk),
    .rst     (rst),
    .I       (sel),
    .mode    (mode),
    .start   (start),
    .idle    (idle),
    .LED     (led),
    .running (running),
    .tick    (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int ticks_seen;
    logic [15:0] exp_led;

    vecs[0] = '{2'd2, 4'd0,  16'h0001};
    vecs[1] = '{2'd2, 4'd7,  16'h00FF};
    vecs[2] = '{2'd2, 4'd15, 16'hFFFF};
    vecs[3] = '{2'd2, 4'd3,  16'h000F};
    vecs[4] = '{2'd1, 4'd9,  16'h0200};
    vecs[5] = '{2'd2, 4'd12, 16'h1FFF};
    vecs[6] = '{2'd1, 4'd0,  16'h0001};
    vecs[7] = '{2'd1, 4'd15, 16'h8000};

    rst = 1'b1; sel = '0; mode = '0; start = 1'b0; idle = 1'b0;
    #12;
    check("reset_led", led, 16'h0);
    check("reset_running", running, 1'b0);
    check("reset_tick", tick, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;

    // ONEHOT sweep with start held high
    mode = 2'd1; sel = 4'd0; start = 1'b1;
    step(1);
    check("onehot_running", running, 1'b1);
    check("onehot_led_entry", led, 16'h0);
    step(1);
    check("onehot_i0", led, 16'h0001);
    for (int i = 1; i < 16; i++) begin
      sel = 4'(i);
      step(1);
      check($sformatf("onehot_i%0d", i), led, 32'(16'h1 << i));
      step(7);
      check($sformatf("onehot_hold_i%0d", i), led, 32'(16'h1 << i));
    end

    // Table-driven BAR / ONEHOT vectors, each visible one clock after the change
    for (int v = 0; v < 8; v++) begin
      mode = vecs[v].mode;
      sel  = vecs[v].sel;
      step(1);
      check($sformatf("vec%0d_m%0d_i%0d", v, vecs[v].mode, vecs[v].sel), led, vecs[v].exp_led);
    end

    // idle during RUN blanks next cycle; idle beats start
    idle = 1'b1;
    step(1);
    check("idle_stop_led", led, 16'h0);
    check("idle_stop_running", running, 1'b0);
    step(3);
    check("prio_running", running, 1'b0);
    check("prio_led", led, 16'h0);
    idle = 1'b0; start = 1'b0;
    step(1);

    // Reset in the middle of CHASE
    mode = 2'd3; sel = 4'd2; start = 1'b1;
    step(1);
    start = 1'b0;
    step(6);
    check("pre_reset_running", running, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("midreset_led", led, 16'h0);
    check("midreset_running", running, 1'b0);
    check("midreset_tick", tick, 1'b0);
    step(2);
    rst = 1'b0;
    ticks_seen = 0;
    for (int k = 0; k < 12; k++) begin
      step(1);
      if (tick || running) ticks_seen++;
    end
    check("no_tick_before_start", ticks_seen, 0);

    // CHASE after reset behaves as first start
    mode = 2'd3; sel = 4'd14; start = 1'b1;
    step(1);
    start = 1'b0;
    check("chase_running", running, 1'b1);
    step(1);
    check("chase_first", led, 16'h4000);
    step(3);
    check("chase_hold", led, 16'h4000);
    step(1);
    check("chase_second", led, 16'h8000);
    step(4);
`ifdef LED_BOUNCE_EN
    check("chase_bounce", led, 16'h4000);
`else
    check("chase_wrap", led, 16'h0001);
`endif

    // idle during CHASE, then restart reloads pos from I
    idle = 1'b1;
    step(1);
    check("chase_idle_led", led, 16'h0);
    check("chase_idle_running", running, 1'b0);
    idle = 1'b0; sel = 4'd5; start = 1'b1;
    step(1);
    start = 1'b0;
    step(1);
    check("chase_reload", led, 16'h0020);
    idle = 1'b1;
    step(1);
    idle = 1'b0;

    // BLINK: LED on for 4 cycles, off for 4; tick every 4th cycle
    mode = 2'd0; sel = 4'd3; start = 1'b1;
    for (int k = 0; k < 16; k++) begin
      step(1);
      check($sformatf("blink_tick_k%0d", k), tick, (k % 4) == 3);
      if (k == 0) exp_led = 16'h0;
      else        exp_led = ((((k - 1) / 4) % 2) == 0) ? 16'h0008 : 16'h0000;
      check($sformatf("blink_led_k%0d", k), led, exp_led);
    end
    start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
